// File: rtl/prbs_if.sv
// Generator/checker signal bundle: the master drives generator controls and received words;
// the slave returns generated words plus lock and error status.
interface prbs_if #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16
);
  logic [1:0]           mode;
  logic                 gen_en;
  logic                 inject_err;
  logic [DATA_W-1:0]    gen_data;
  logic                 gen_valid;
  logic                 chk_valid;
  logic [DATA_W-1:0]    chk_data;
  logic                 clr_cnt;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_sat;

  modport master (
    output mode, gen_en, inject_err, chk_valid, chk_data, clr_cnt,
    input  gen_data, gen_valid, locked, err_cnt, err_sat
  );

  modport slave (
    input  mode, gen_en, inject_err, chk_valid, chk_data, clr_cnt,
    output gen_data, gen_valid, locked, err_cnt, err_sat
  );
endinterface

// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 generator and lock-tracking checker, DATA_W bits per cycle, MSB earliest.
// Generator output 1 cycle after gen_en; checker status 2 cycles after chk_valid; no backpressure.
module prbs_gen_chk #(
  parameter int DATA_W       = 8,
  parameter int ERR_CNT_W    = 16,
  parameter int LOCK_WORDS   = 8,
  parameter int UNLOCK_WORDS = 4
) (
  input  logic   clk,
  input  logic   rst,
  prbs_if.slave  bus
);
  localparam int MAX_RUN = (LOCK_WORDS > UNLOCK_WORDS) ? LOCK_WORDS : UNLOCK_WORDS;
  localparam int RUN_W   = $clog2(MAX_RUN) + 1;
  localparam int SUM_W   = ERR_CNT_W + 6;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} chk_state_e;

  function automatic logic fb(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    fb = s[6]  ^ s[5];
      2'd1:    fb = s[14] ^ s[13];
      2'd2:    fb = s[22] ^ s[17];
      default: fb = s[30] ^ s[27];
    endcase
  endfunction

  function automatic logic [30:0] seed(input logic [1:0] m);
    case (m)
      2'd0:    seed = 31'h0000_007F;
      2'd1:    seed = 31'h0000_7FFF;
      2'd2:    seed = 31'h007F_FFFF;
      default: seed = 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic [5:0] n_bits(input logic [1:0] m);
    case (m)
      2'd0:    n_bits = 6'd7;
      2'd1:    n_bits = 6'd15;
      2'd2:    n_bits = 6'd23;
      default: n_bits = 6'd31;
    endcase
  endfunction

  chk_state_e           state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [30:0]          gen_s_q, gen_s_d, chk_s_q, chk_s_d;
  logic [DATA_W-1:0]    gen_data_q, gen_data_d, err_bits_q, err_bits_d;
  logic                 gen_valid_q, gen_valid_d, err_vld_q, err_vld_d, filled_q, filled_d;
  logic [5:0]           rx_cnt_q, rx_cnt_d;
  logic [RUN_W-1:0]     clean_run_q, clean_run_d, bad_run_q, bad_run_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_sat_q, err_sat_d;

  logic                 mode_chg;
  logic [30:0]          gen_s_tmp, chk_s_tmp;
  logic [DATA_W-1:0]    gen_word, err_word;
  logic                 pred;
  logic [5:0]           pop, rx_base;
  logic [SUM_W-1:0]     err_sum;

  assign mode_chg = (bus.mode != mode_q);

  always_comb begin
    mode_d      = bus.mode;
    gen_s_d     = gen_s_q;
    gen_data_d  = gen_data_q;
    gen_valid_d = gen_valid_q;
    gen_s_tmp   = gen_s_q;
    gen_word    = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      gen_word[i] = fb(gen_s_tmp, mode_q);
      gen_s_tmp   = {gen_s_tmp[29:0], gen_word[i]};
    end
    if (mode_chg) begin
      gen_s_d     = seed(bus.mode);
      gen_valid_d = 1'b0;
    end else if (bus.gen_en) begin
      gen_s_d                = gen_s_tmp;
      gen_data_d             = gen_word;
      gen_data_d[DATA_W-1]   = gen_word[DATA_W-1] ^ bus.inject_err;
      gen_valid_d            = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    clean_run_d = clean_run_q;
    bad_run_d   = bad_run_q;
    err_cnt_d   = err_cnt_q;
    err_sat_d   = err_sat_q;
    pop         = '0;
    for (int i = 0; i < DATA_W; i++) pop = pop + 6'(err_bits_q[i]);
    err_sum = SUM_W'(err_cnt_q) + SUM_W'(pop);

    // Stage 1: act on the error bits registered from last cycle's word.
    if (err_vld_q) begin
      if (state_q == SEARCH) begin
        if (pop == '0 && filled_q) begin
          if (clean_run_q == RUN_W'(LOCK_WORDS - 1)) begin
            state_d     = LOCKED;
            clean_run_d = '0;
          end else begin
            clean_run_d = clean_run_q + RUN_W'(1);
          end
        end else begin
          clean_run_d = '0;
        end
      end else begin
        if (err_sum >= SUM_W'(CNT_MAX)) begin
          err_cnt_d = CNT_MAX;
          err_sat_d = 1'b1;
        end else begin
          err_cnt_d = err_sum[ERR_CNT_W-1:0];
        end
        if (pop != '0) begin
          if (bad_run_q == RUN_W'(UNLOCK_WORDS - 1)) begin
            state_d   = SEARCH;
            bad_run_d = '0;
          end else begin
            bad_run_d = bad_run_q + RUN_W'(1);
          end
        end else begin
          bad_run_d = '0;
        end
      end
    end
    if (bus.clr_cnt) begin
      err_cnt_d = '0;
      err_sat_d = 1'b0;
    end
    if (mode_chg) begin
      state_d     = SEARCH;
      clean_run_d = '0;
      bad_run_d   = '0;
    end

    // Stage 0: the incoming word sees the state chosen above, so a fresh lock free-runs at once.
    rx_base   = (state_q == SEARCH && !mode_chg) ? rx_cnt_q : '0;
    chk_s_tmp = chk_s_q;
    err_word  = '0;
    pred      = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      pred        = fb(chk_s_tmp, mode_q);
      err_word[i] = bus.chk_data[i] ^ pred;
      chk_s_tmp   = {chk_s_tmp[29:0], (state_d == LOCKED) ? pred : bus.chk_data[i]};
    end
    err_bits_d = err_word;
    err_vld_d  = bus.chk_valid && !mode_chg;
    filled_d   = (state_d == LOCKED) || (rx_base >= n_bits(mode_q));
    chk_s_d    = chk_s_q;
    rx_cnt_d   = rx_base;
    if (err_vld_d) begin
      chk_s_d  = chk_s_tmp;
      rx_cnt_d = (rx_base > 6'd63 - 6'(DATA_W)) ? 6'd63 : rx_base + 6'(DATA_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      mode_q      <= bus.mode;
      gen_s_q     <= seed(bus.mode);
      chk_s_q     <= '0;
      gen_data_q  <= '0;
      gen_valid_q <= 1'b0;
      err_bits_q  <= '0;
      err_vld_q   <= 1'b0;
      filled_q    <= 1'b0;
      rx_cnt_q    <= '0;
      clean_run_q <= '0;
      bad_run_q   <= '0;
      err_cnt_q   <= '0;
      err_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      gen_s_q     <= gen_s_d;
      chk_s_q     <= chk_s_d;
      gen_data_q  <= gen_data_d;
      gen_valid_q <= gen_valid_d;
      err_bits_q  <= err_bits_d;
      err_vld_q   <= err_vld_d;
      filled_q    <= filled_d;
      rx_cnt_q    <= rx_cnt_d;
      clean_run_q <= clean_run_d;
      bad_run_q   <= bad_run_d;
      err_cnt_q   <= err_cnt_d;
      err_sat_q   <= err_sat_d;
    end
  end

  assign bus.gen_data  = gen_data_q;
  assign bus.gen_valid = gen_valid_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_cnt   = err_cnt_q;
  assign bus.err_sat   = err_sat_q;
endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Parametrised PRBS generator and checker, the successor to the fixed PRBS31 tile. It adds selectable PRBS7/15/23/31 polynomials and a DATA_W-bit parallel output per clock. It also adds a lock-tracking checker with a saturating bit-error counter and single-bit error injection. It sits between the pad-level wrapper and the I/O mux, and supports external loopback (gen_data → pins → chk_data) for link and board bring-up.

## Interface
- DATA_W, 8: bits generated and checked per cycle; 1..32.
- ERR_CNT_W, 16: error counter width.
- LOCK_WORDS, 8: consecutive clean words needed to lock; LOCK_WORDS*DATA_W ≥ 32 required.
- UNLOCK_WORDS, 4: consecutive errored words that drop lock.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  00 PRBS7 (x^7+x^6+1), 01 PRBS15 (x^15+x^14+1), 10 PRBS23 (x^23+x^18+1), 11 PRBS31 (x^31+x^28+1).
- gen_en  in  1  advance generator one word.
- inject_err  in  1  flip MSB of the word produced this cycle; ignored when gen_en=0.
- gen_data  out  DATA_W  generated word; MSB is the earliest bit.
- gen_valid  out  1  gen_data holds a new word.
- chk_valid  in  1  chk_data holds a word to check.
- chk_data  in  DATA_W  received word; MSB is the earliest bit.
- clr_cnt  in  1  clear err_cnt and err_sat.
- locked  out  1  checker is in LOCKED.
- err_cnt  out  ERR_CNT_W  bit errors counted while locked.
- err_sat  out  1  err_cnt has saturated.

## Operation
- LFSR: Fibonacci, N=7/15/23/31, tap T=6/14/18/28. Per bit: b = s[N-1]^s[T-1]; s = {s[N-2:0], b}; output b. DATA_W steps are unrolled per cycle.
- Generator: seed is all ones in the low N bits. With gen_en=1, gen_data is loaded with the next DATA_W bits and the state advances. With gen_en=0, gen_data, gen_valid and the state hold.
- inject_err: affects the output word only. The LFSR state is unaffected, so exactly one bit error appears downstream.
- Checker states:
  - SEARCH (reset state): self-synchronising. Each received bit is the shift-in, predicted bit = s[N-1]^s[T-1], error bit = received^predicted. A word is clean only when all its error bits are 0 and at least N bits have been received since entering SEARCH. A non-clean word resets the clean-run counter. LOCK_WORDS consecutive clean words → LOCKED.
  - LOCKED: free-running. Each word the LFSR shifts in its own predicted bits and ignores the data. err_cnt += popcount(error bits), saturating at all-ones, with err_sat=1 on saturation. UNLOCK_WORDS consecutive words with any error → SEARCH; a clean word resets that run.
- Words with chk_valid=0 are ignored: no state change and no run-counter change.
- Mode change: the first cycle mode differs from its registered value does all of the following:
  - reseeds the generator;
  - forces the checker to SEARCH and clears its run counters and received-bit count;
  - deasserts gen_valid for that cycle.
  - err_cnt is retained.
- clr_cnt: sets err_cnt=0 and err_sat=0 next cycle. If clr_cnt coincides with a counted error, the clear wins and that word's errors are dropped.
- rst: gen_data=0, gen_valid=0, generator state = seed, mode register = mode input, checker in SEARCH with counters 0, locked=0, err_cnt=0, err_sat=0. Reset mid-run aborts everything within one cycle.

## Timing
- gen_data and gen_valid appear 1 cycle after the gen_en cycle.
- Error bits are registered 1 cycle after the chk_valid cycle. err_cnt and err_sat update 2 cycles after the chk_valid cycle.
- locked rises 2 cycles after the LOCK_WORDS-th clean word is presented. locked falls 2 cycles after the UNLOCK_WORDS-th errored word.
- Throughput: one word per cycle, both directions, no stalls.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: hold rst for 3 cycles with random inputs → all outputs 0 and locked=0 for those cycles and for 1 cycle after release.
- PRBS7 sequence, DATA_W=8: reset then gen_en=1 → first gen_data=0x02. Next 2^7−1 bits match a bit-serial reference model. The sequence repeats after 127 bits.
- Loopback lock, all 4 modes: gen_data→chk_data and gen_valid→chk_valid, gen_en=1 → locked=1 within ceil(N/8)+LOCK_WORDS+3 cycles, and err_cnt stays 0 for 10000 cycles.
- Error injection: while locked, pulse inject_err on 3 separate cycles → err_cnt=3 exactly and locked stays 1.
- Loss of lock: while locked, drive chk_data=0xFF → locked=0 after UNLOCK_WORDS words plus 2 cycles. Restore loopback → relock.
- Saturation and clear, ERR_CNT_W=4: with chk_data = inverted gen_data while locked, 2 words (16 errors) → err_cnt=15 and err_sat=1. Pulse clr_cnt → err_cnt=0 and err_sat=0. A mode change mid-run → locked=0 next cycle, then relock.
